// File: rtl/cu_multicycle_if.sv
// cu_multicycle_if: fetch handshake, memory/MDU handshakes, datapath controls and trap flags of the multi-cycle control unit
//   slave  : control-unit side (consumes instr/handshakes, drives controls)
//   master : fetch/datapath side (drives instr/handshakes, observes controls)
interface cu_multicycle_if #(parameter int INSTR_W = 16);
  logic [INSTR_W-1:0] instr;
  logic instr_valid, instr_ready, mem_ack, mdu_done;
  logic [3:0] alu_fc, cmp;
  logic [2:0] alu_src, wb_sel, reg_we;
  logic [1:0] imm_op, pc_sel;
  logic jump, alu_res, mov, sz, sb, mem_re, mem_we, halted, illegal, fault;
  modport slave (
    input instr, instr_valid, mem_ack, mdu_done,
    output instr_ready, alu_fc, cmp, alu_src, wb_sel, reg_we, imm_op, pc_sel,
    output jump, alu_res, mov, sz, sb, mem_re, mem_we, halted, illegal, fault
  );
  modport master (
    output instr, instr_valid, mem_ack, mdu_done,
    input instr_ready, alu_fc, cmp, alu_src, wb_sel, reg_we, imm_op, pc_sel,
    input jump, alu_res, mov, sz, sb, mem_re, mem_we, halted, illegal, fault
  );
endinterface

// File: rtl/cu_multicycle.sv
// cu_multicycle: multi-cycle control unit stepping one fetched instruction through DECODE/EXEC/MEM/MDU/WB
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave side of cu_multicycle_if (fetch valid/ready, mem_ack, mdu_done, datapath controls, halted/illegal/fault)
module cu_multicycle #(
  parameter int INSTR_W = 16,
  parameter int MEM_TIMEOUT = 15,
  parameter bit EN_MDU = 1'b1
) (
  input logic clk,
  input logic rst,
  cu_multicycle_if.slave bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, MDU, WB, HALT} state_t;
  typedef struct packed {
    logic [3:0] alu_fc;
    logic [2:0] alu_src, wb_sel, reg_we;
    logic [1:0] imm_op;
    logic alu_res, mov, sz, sb;
  } ctrl_t;
  state_t state_q, state_d;
  ctrl_t ctrl_q, ctrl_d, dec;
  logic [3:0] op_q, op_d, fc_q, fc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic illegal_q, illegal_d, fault_q, fault_d;
  logic is_r, is_imm, is_mem, is_ld, is_br, is_jmp, is_mdu, bad;
  assign is_r = op_q == 4'b1111;
  assign is_imm = op_q[3:1] == 3'b100;
  assign is_mem = op_q inside {[4'b1010:4'b1101]};
  assign is_ld = is_mem && !op_q[0];
  assign is_br = op_q inside {4'b0100, 4'b0101, 4'b0110};
  assign is_jmp = op_q == 4'b0001;
  assign is_mdu = is_r && fc_q[3:1] == 3'b010;
  assign bad = op_q inside {4'b0010, 4'b0011, 4'b0111, 4'b1110}
            || (is_r && !(fc_q inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd7, 4'd8}))
            || (is_mdu && !EN_MDU);
  always_comb begin
    dec = '0;
    dec.alu_fc = is_r ? fc_q : 4'd0;
    dec.alu_src = is_mem ? 3'b001 : is_imm ? 3'b010 : 3'b000;
    dec.wb_sel = is_ld ? 3'b001 : is_mdu ? 3'b011 : (is_r && fc_q == 4'd8) ? 3'b010 : 3'b000;
    dec.reg_we = is_mdu ? 3'b101 : (is_r && fc_q == 4'd7) ? 3'b011 : (is_r || is_imm || is_ld) ? 3'b001 : 3'b000;
    dec.imm_op = {op_q == 4'b1001, op_q == 4'b1000};
    dec.alu_res = is_r || is_imm;
    dec.mov = is_r && fc_q == 4'd8;
    dec.sz = is_imm || op_q[3:1] == 3'b110;
    dec.sb = op_q[3:1] == 3'b101;
  end
  always_comb begin
    state_d = state_q;
    ctrl_d = ctrl_q;
    op_d = op_q;
    fc_d = fc_q;
    cnt_d = '0;
    illegal_d = illegal_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: if (bus.instr_valid) begin
        op_d = bus.instr[INSTR_W-1 -: 4];
        fc_d = bus.instr[3:0];
        state_d = DECODE;
      end
      DECODE: begin
        state_d = (op_q == 4'b0000 || bad) ? HALT : EXEC;
        illegal_d = illegal_q | bad;
        ctrl_d = dec;
      end
      EXEC: state_d = (is_br || is_jmp) ? IDLE : is_mem ? MEM : is_mdu ? MDU : WB;
      // an ack arriving on the last allowed cycle still completes the access
      MEM: if (bus.mem_ack) state_d = is_ld ? WB : IDLE;
        else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d = HALT;
          fault_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
      MDU: state_d = bus.mdu_done ? WB : MDU;
      WB: state_d = IDLE;
      default: state_d = HALT;
    endcase
    if (state_d == IDLE || state_d == HALT) ctrl_d = '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      op_q <= '0;
      fc_q <= '0;
      cnt_q <= '0;
      illegal_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      op_q <= op_d;
      fc_q <= fc_d;
      cnt_q <= cnt_d;
      illegal_q <= illegal_d;
      fault_q <= fault_d;
    end
  // ready is forced low while reset is held, even though the state already reads IDLE
  assign bus.instr_ready = state_q == IDLE && !rst;
  assign bus.alu_fc = ctrl_q.alu_fc;
  assign bus.alu_src = ctrl_q.alu_src;
  assign bus.wb_sel = ctrl_q.wb_sel;
  assign bus.imm_op = ctrl_q.imm_op;
  assign bus.alu_res = ctrl_q.alu_res;
  assign bus.mov = ctrl_q.mov;
  assign bus.sz = ctrl_q.sz;
  assign bus.sb = ctrl_q.sb;
  assign bus.reg_we = state_q == WB ? ctrl_q.reg_we : 3'b000;
  assign bus.mem_re = state_q == MEM && is_ld;
  assign bus.mem_we = state_q == MEM && !is_ld;
  assign bus.pc_sel = state_q == EXEC ? {is_jmp, is_br} : 2'b00;
  assign bus.jump = state_q == EXEC && is_jmp;
  assign bus.cmp = (state_q == EXEC && is_br) ? op_q : 4'd0;
  assign bus.halted = state_q == HALT;
  assign bus.illegal = illegal_q;
  assign bus.fault = fault_q;
endmodule
